// File: rtl/hex_probe_pkg.sv
// rtl/hex_probe_pkg.sv - shared types, seven-segment font and default parameters for hex_probe_display
package hex_probe_pkg;

    typedef logic [6:0] seg7_t;

    localparam int DEF_NUM_CH          = 4;
    localparam int DEF_NUM_DIGITS      = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_STEP_DIV        = 25000000;

    // Active-low segments, bit 0 = a ... bit 6 = g, indexed by nibble value.
    localparam seg7_t SEG_FONT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_probe_display_btn_debounce.sv
// rtl/hex_probe_display_btn_debounce.sv - button synchronizer, debounce counter and press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    // Synchronizer holds the pressed (active-high) sense so its cleared state means released.
    logic [1:0]    sync;
    logic          level_n;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= '0;
            level_n <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync  <= {sync[0], ~btn_n};
            press <= 1'b0;
            if (sync[1] != level_n) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt     <= '0;
                level_n <= ~level_n;
                press   <= level_n;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hex_probe_display.sv
// rtl/hex_probe_display.sv - selects one of several 32-bit probe channels for a seven-segment display and generates a debug step enable
module hex_probe_display
    import hex_probe_pkg::*;
#(
    parameter int NUM_CH          = DEF_NUM_CH,
    parameter int NUM_DIGITS      = DEF_NUM_DIGITS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STEP_DIV        = DEF_STEP_DIV
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CH*32-1:0]      probe,
    input  logic                      btn_sel_n,
    input  logic                      btn_step_n,
    input  logic                      mode_run,
    input  logic                      freeze,
    output logic [NUM_DIGITS*7-1:0]   hex,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      step_en
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int DIV_W = $clog2(STEP_DIV);

    logic             sel_press;
    logic             step_press;
    logic [31:0]      disp_val;
    logic             mode_q;
    logic             mode_chg;
    logic [DIV_W-1:0] div;
    logic             step_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (btn_sel_n),
        .press   (sel_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (btn_step_n),
        .press   (step_press)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_sel   <= '0;
            disp_val <= '0;
        end else begin
            if (sel_press && !freeze)
                ch_sel <= (ch_sel == CH_W'(NUM_CH - 1)) ? '0 : ch_sel + CH_W'(1);
            if (!freeze)
                disp_val <= probe[{ch_sel, 5'd0} +: 32];
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign hex[7*i +: 7] = SEG_FONT[disp_val[4*i +: 4]];
    end

    assign mode_chg = mode_run ^ mode_q;

    // The divider restarts from 0 whenever the mode flips or manual mode is active.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= 1'b0;
            div    <= '0;
            step_q <= 1'b0;
        end else begin
            mode_q <= mode_run;
            step_q <= step_press & ~mode_run;
            if (mode_chg || !mode_run || div == DIV_W'(STEP_DIV - 1))
                div <= '0;
            else
                div <= div + DIV_W'(1);
        end
    end

    assign step_en = reset_n && !mode_chg &&
                     (mode_run ? (div == DIV_W'(STEP_DIV - 1)) : step_q);

endmodule

// File: tb/tb_hex_probe_display.sv
// tb/tb_hex_probe_display.sv - self-checking bench for hex_probe_display
module tb_hex_probe_display;

    localparam int NUM_CH = 4;
    localparam int NUM_DIGITS = 8;
    localparam int DEB = 4;
    localparam int SDIV = 5;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [127:0] probe;
    logic         btn_sel_n = 1'b1;
    logic         btn_step_n = 1'b1;
    logic         mode_run = 1'b0;
    logic         freeze = 1'b0;
    logic [55:0]  hex;
    logic [1:0]   ch_sel;
    logic         step_en;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] val;
        logic [55:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    hex_probe_display #(
        .NUM_CH          (NUM_CH),
        .NUM_DIGITS      (NUM_DIGITS),
        .DEBOUNCE_CYCLES (DEB),
        .STEP_DIV        (SDIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .probe      (probe),
        .btn_sel_n  (btn_sel_n),
        .btn_step_n (btn_step_n),
        .mode_run   (mode_run),
        .freeze     (freeze),
        .hex        (hex),
        .ch_sel     (ch_sel),
        .step_en    (step_en)
    );

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [55:0] exp_hex(input logic [31:0] v);
        logic [55:0] r;
        for (int d = 0; d < 8; d++) r[7*d +: 7] = font(v[4*d +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] chan(input int c);
        return probe[32*c +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press_sel();
        btn_sel_n = 1'b0;
        repeat (8) tick();
        btn_sel_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic wait_ch(input int want, input string name);
        int n = 0;
        while (ch_sel != want[1:0] && n < 20) begin
            tick();
            n++;
        end
        check(name, ch_sel, want);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [31:0] model;
        logic [55:0] held;
        int          pulses;
        int          doubles;
        logic        prev;
        logic        fz;

        probe = {32'hCAFEF00D, 32'h0F1E2D3C, 32'h9ABCDEF0, 32'h12345678};

        // Reset values and first-cycle latency
        repeat (3) tick();
        check("reset_hex", hex, {8{7'b1000000}});
        check("reset_ch_sel", ch_sel, 0);
        check("reset_step_en", step_en, 0);
        reset_n = 1'b1;
        check("hex_before_first_edge", hex, {8{7'b1000000}});
        tick();
        check("hex_after_release", hex, exp_hex(32'h12345678));
        check("digit7_is_1", hex[55:49], 7'b1111001);
        check("digit0_is_8", hex[6:0], 7'b0000000);

        // Font and latency vectors on channel 0
        vecs[0] = '{32'h00000000, {8{7'b1000000}}};
        vecs[1] = '{32'h88888888, 56'd0};
        vecs[2] = '{32'hFFFFFFFF, {8{7'b0001110}}};
        vecs[3] = '{32'hAAAAAAAA, {8{7'b0001000}}};
        vecs[4] = '{32'h01234567, exp_hex(32'h01234567)};
        vecs[5] = '{32'h89ABCDEF, exp_hex(32'h89ABCDEF)};
        for (int i = 0; i < 6; i++) begin
            probe[31:0] = vecs[i].val;
            #1;
            check("vec_latency_hold", hex, (i == 0) ? exp_hex(32'h12345678) : vecs[i-1].exp);
            tick();
            check("vec_decode", hex, vecs[i].exp);
        end
        probe[31:0] = 32'h12345678;
        tick();

        // Short and bouncing presses must not advance
        btn_sel_n = 1'b0; repeat (3) tick();
        btn_sel_n = 1'b1; tick();
        btn_sel_n = 1'b0; repeat (3) tick();
        btn_sel_n = 1'b1; tick();
        btn_sel_n = 1'b0; tick();
        btn_sel_n = 1'b1; repeat (10) tick();
        check("bounce_no_advance", ch_sel, 0);

        btn_sel_n = 1'b0;
        repeat (6) tick();
        btn_sel_n = 1'b1;
        wait_ch(1, "stable_press_advance");
        check("hex_still_ch0", hex, exp_hex(chan(0)));
        tick();
        check("hex_shows_ch1", hex, exp_hex(chan(1)));
        repeat (12) tick();
        check("release_no_advance", ch_sel, 1);

        // Wrap sequence
        press_sel();
        press_sel();
        check("sel_reaches_3", ch_sel, 3);
        for (int i = 0; i < 4; i++) begin
            press_sel();
            check("sel_wrap_seq", ch_sel, i);
        end

        // Freeze holds channel and value; presses are not queued
        check("hex_ch3", hex, exp_hex(chan(3)));
        held = exp_hex(chan(3));
        freeze = 1'b1;
        tick();
        probe[127:96] = 32'h55AA33CC;
        press_sel();
        check("freeze_ch_sel", ch_sel, 3);
        check("freeze_hex", hex, held);
        freeze = 1'b0;
        repeat (3) tick();
        check("freeze_not_queued", ch_sel, 3);
        check("unfreeze_hex", hex, exp_hex(32'h55AA33CC));

        // Random probes and freeze against a last-unfrozen-sample model
        model = chan(3);
        for (int i = 0; i < 100; i++) begin
            probe = {$urandom, $urandom, $urandom, $urandom};
            fz = ($urandom_range(0, 3) == 0);
            freeze = fz;
            tick();
            if (!fz) model = chan(3);
            check("random_hex", hex, exp_hex(model));
        end
        freeze = 1'b0;
        tick();

        // Free-run stepping: pulse on every SDIV-th cycle after the mode change
        mode_run = 1'b1;
        #1;
        check("run_change_cycle", step_en, 0);
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("run_period", step_en, (k % SDIV) == 0);
            if (step_en) pulses++;
        end
        check("run_pulse_count", pulses, 4);

        repeat (2) tick();
        mode_run = 1'b0;
        #1;
        check("toggle_change_cycle", step_en, 0);
        tick();
        mode_run = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            btn_step_n = !(k >= 14 && k < 22);
            tick();
            check("run_restart_period", step_en, (k % SDIV) == 0);
        end
        btn_step_n = 1'b1;

        mode_run = 1'b0;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (step_en) pulses++;
        end
        check("run_press_not_queued", pulses, 0);

        // Manual stepping: two presses, two single-cycle pulses
        pulses = 0;
        doubles = 0;
        prev = 1'b0;
        for (int k = 0; k < 40; k++) begin
            btn_step_n = !((k >= 2 && k < 10) || (k >= 20 && k < 28));
            tick();
            if (step_en) pulses++;
            if (step_en && prev) doubles++;
            prev = step_en;
        end
        check("manual_pulse_count", pulses, 2);
        check("manual_single_cycle", doubles, 0);

        // Asynchronous reset mid-divide and mid-debounce
        mode_run = 1'b1;
        repeat (2) tick();
        btn_sel_n = 1'b0;
        repeat (3) tick();
        check("pre_reset_step", step_en, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_ch_sel", ch_sel, 0);
        check("async_reset_hex", hex, {8{7'b1000000}});
        check("async_reset_step", step_en, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("post_reset_period", step_en, (k % SDIV) == 0);
            if (k == DEB) check("held_press_not_early", ch_sel, 0);
        end
        check("held_press_after_debounce", ch_sel, 1);
        btn_sel_n = 1'b1;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
